// File: rtl/dmem_wt_port.sv
// Write-through data-memory port: single-cycle local RAM plus a store FIFO
// that forwards every core store to an external write bus.
module dmem_wt_port #(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned FIFO_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          data_addr,
  input  logic [31:0]          data_out,
  input  logic                 data_rd_wr,
  output logic [31:0]          data_in,
  output logic                 bus_valid,
  output logic [31:0]          bus_addr,
  output logic [31:0]          bus_wdata,
  input  logic                 bus_ready,
  output logic [FIFO_LOG2:0]   fifo_count,
  output logic                 overflow
);

  localparam int unsigned WORDS = 1 << ADDR_W;
  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned PTR_W = FIFO_LOG2;
  localparam int unsigned CNT_W = FIFO_LOG2 + 1;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_W + 2));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  logic [31:0] ram [WORDS];
  entry_t      fifo_mem [DEPTH];

  logic [31:0]       data_in_q, data_in_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              bus_valid_q, bus_valid_d;
  logic              overflow_q, overflow_d;
  entry_t            head_q, head_d;

  logic              in_range;
  logic [ADDR_W-1:0] ram_idx;
  logic              is_store;
  logic              ram_we;
  logic              pop;
  logic              full;
  logic              push_acc;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  entry_t            new_entry;

  // Address decode and handshake qualification
  always_comb begin
    in_range   = ({1'b0, data_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, data_addr} < LIMIT);
    ram_idx    = ADDR_W'((data_addr - BASE_ADDR) >> 2);
    is_store   = !reset && !data_rd_wr;
    ram_we     = is_store && in_range;
    pop        = bus_valid_q && bus_ready;
    full       = (count_q == CNT_W'(DEPTH));
    push_acc   = is_store && (!full || pop);
    rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    new_entry  = '{addr: data_addr, data: data_out};
  end

  // Next-state for load data, FIFO bookkeeping and the registered bus head
  always_comb begin
    data_in_d   = data_in_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    head_d      = head_q;

    if (data_rd_wr) begin
      data_in_d = in_range ? ram[ram_idx] : 32'h0;
    end

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_nxt;
    end

    case ({push_acc, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (is_store && full && !pop) begin
      overflow_d = 1'b1;
    end

    // The pushed entry becomes the head only when the queue is (or is about to be) empty
    if (push_acc && ((count_q == CNT_W'(0)) || ((count_q == CNT_W'(1)) && pop))) begin
      head_d = new_entry;
    end else if (pop) begin
      head_d = fifo_mem[rd_ptr_nxt];
    end

    bus_valid_d = (count_d != CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_in_q   <= 32'h0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bus_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      head_q      <= '0;
    end else begin
      data_in_q   <= data_in_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bus_valid_q <= bus_valid_d;
      overflow_q  <= overflow_d;
      head_q      <= head_d;
    end
  end

  // Storage arrays carry no reset; RAM contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      fifo_mem[wr_ptr_q] <= new_entry;
    end
  end

  assign data_in    = data_in_q;
  assign bus_valid  = bus_valid_q;
  assign bus_addr   = head_q.addr;
  assign bus_wdata  = head_q.data;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_dmem_wt_port.sv
// Bench for dmem_wt_port: directed scenarios then random traffic, all
// checked against a queue/associative-array model of the port.
module tb_dmem_wt_port;

  localparam int unsigned ADDR_W    = 10;
  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam int unsigned FIFO_LOG2 = 2;
  localparam int unsigned DEPTH     = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        data_addr;
  logic [31:0]        data_out;
  logic               data_rd_wr;
  logic [31:0]        data_in;
  logic               bus_valid;
  logic [31:0]        bus_addr;
  logic [31:0]        bus_wdata;
  logic               bus_ready;
  logic [FIFO_LOG2:0] fifo_count;
  logic               overflow;

  always #5 clk = ~clk;

  dmem_wt_port #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .FIFO_LOG2(FIFO_LOG2)) dut (
    .clk(clk), .reset(reset), .data_addr(data_addr), .data_out(data_out),
    .data_rd_wr(data_rd_wr), .data_in(data_in), .bus_valid(bus_valid),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  logic [31:0] m_ram [int];
  ent_t        m_q [$];
  bit          m_ovf;
  logic [31:0] m_din;
  bit          m_din_known;
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(BASE);
    return (ua >= ub) && (ua < ub + 4 * (64'd1 << ADDR_W));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(BASE);
    return int'((ua - ub) / 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("bus_valid", 32'(bus_valid), 32'(m_q.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() != 0) begin
      chk("bus_addr", bus_addr, m_q[0].a);
      chk("bus_wdata", bus_wdata, m_q[0].d);
    end
    if (m_din_known) chk("data_in", data_in, m_din);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after
  task automatic step(input logic rst, input logic rw, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    bit do_pop;
    reset      = rst;
    data_rd_wr = rw;
    data_addr  = a;
    data_out   = d;
    bus_ready  = rdy;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_ovf       = 1'b0;
      m_din       = 32'h0;
      m_din_known = 1'b1;
    end else begin
      do_pop = (m_q.size() != 0) && rdy;
      if (rw) begin
        if (!in_rng(a)) begin
          m_din = 32'h0;
          m_din_known = 1'b1;
        end else if (m_ram.exists(word_of(a))) begin
          m_din = m_ram[word_of(a)];
          m_din_known = 1'b1;
        end else begin
          m_din_known = 1'b0;
        end
      end else if (in_rng(a)) begin
        m_ram[word_of(a)] = d;
      end
      if (do_pop) void'(m_q.pop_front());
      if (!rw) begin
        if (m_q.size() < DEPTH) m_q.push_back('{a: a, d: d});
        else m_ovf = 1'b1;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, BASE + 32'h0FF0, 32'h0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; data_rd_wr = 1'b1; data_addr = '0; data_out = '0; bus_ready = 1'b0;
    m_ovf = 1'b0; m_din = '0; m_din_known = 1'b0;

    step(1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, BASE, 32'h5555_5555, 1'b0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_data_in", data_in, 32'h0);

    // Store then immediate read of the same word
    step(1'b0, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);
    chk("first_store_count", 32'(fifo_count), 32'd1);
    step(1'b0, 1'b1, BASE + 32'h10, 32'h0, 1'b0);
    chk("raw_read", data_in, 32'hDEAD_BEEF);
    drain();

    // Out-of-range read and store leave the aliased RAM word untouched
    step(1'b0, 1'b0, BASE + 32'h0FF0, 32'hCAFE_0001, 1'b1);
    drain();
    step(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0, 1'b0);
    chk("oor_read", data_in, 32'h0);
    step(1'b0, 1'b0, 32'hFFFF_FFF0, 32'h1234_5678, 1'b0);
    chk("oor_count", 32'(fifo_count), 32'd1);
    chk("oor_bus_addr", bus_addr, 32'hFFFF_FFF0);
    step(1'b0, 1'b1, BASE + 32'h0FF0, 32'h0, 1'b1);
    chk("oor_ram_kept", data_in, 32'hCAFE_0001);
    drain();

    // Unaligned store lands on the containing word
    step(1'b0, 1'b0, BASE + 32'h7, 32'hA5A5_0007, 1'b0);
    chk("unaligned_bus_addr", bus_addr, BASE + 32'h7);
    step(1'b0, 1'b1, BASE + 32'h4, 32'h0, 1'b0);
    chk("unaligned_word", data_in, 32'hA5A5_0007);
    drain();

    // Overflow: fifth store is dropped
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, BASE + 32'h100 + 32'(4 * i), 32'h0B00_0000 + 32'(i), 1'b0);
    chk("ovf_count", 32'(fifo_count), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    step(1'b0, 1'b1, BASE + 32'h10, 32'h0, 1'b1);
    chk("ovf_head_after_pop", bus_wdata, 32'h0B00_0001);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous push/pop, wrapping pointers several times
    step(1'b1, 1'b1, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, BASE + 32'h200 + 32'(4 * i), 32'h0C00_0000 + 32'(i), 1'b0);
    for (int i = 4; i < 14; i++)
      step(1'b0, 1'b0, BASE + 32'h200 + 32'(4 * i), 32'h0C00_0000 + 32'(i), 1'b1);
    chk("full_pp_count", 32'(fifo_count), 32'd4);
    chk("full_pp_ovf", 32'(overflow), 32'd0);
    chk("full_pp_head", bus_wdata, 32'h0C00_000A);
    drain();

    // Reset discards queue, suppresses store, preserves RAM
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, BASE + 32'h300 + 32'(4 * i), 32'h0D00_0000 + 32'(i), 1'b0);
    step(1'b1, 1'b0, BASE + 32'h10, 32'h1111_1111, 1'b0);
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    step(1'b0, 1'b1, BASE + 32'h10, 32'h0, 1'b0);
    chk("rst_ram_kept", data_in, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, BASE + 32'h304, 32'h0, 1'b0);
    chk("rst_ram_kept2", data_in, 32'h0D00_0001);

    // Random traffic around the mapped window
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      logic        rw;
      logic        rdy;
      logic        rst;
      if ($urandom_range(0, 15) == 0)
        a = BASE - 32'(16) + 32'($urandom_range(0, 31));
      else if ($urandom_range(0, 15) == 0)
        a = BASE + 32'h1000 - 32'(8) + 32'($urandom_range(0, 31));
      else
        a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      rw  = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step(rst, rw, a, $urandom, rdy);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
